// File: rtl/pin_func_pkg.sv
// Shared types and width helpers for the pad-function multiplexer.
package pin_func_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GAP    = 1'b1
  } lane_state_t;

  localparam int unsigned FUNC_GPIO = 0;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the value max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pin_func_lane.sv
// One pad lane: input synchroniser, optional debounce (PIN_FUNC_DEBOUNCE_EN), edge detect,
// break-before-make function switch FSM and registered output mux.
module pin_func_lane
  import pin_func_pkg::*;
#(
  parameter int unsigned NFUNC   = 4,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned DEB_CYC = 8,
  localparam int unsigned FW     = idx_width(NFUNC)
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset_n,
  input  logic             wr_en,
  input  logic [FW-1:0]    wr_func,
  input  logic [NFUNC-1:0] func_write,
  input  logic [NFUNC-1:0] func_writeEnable,
  input  logic             pad_read,
  output logic             pad_write,
  output logic             pad_writeEnable,
  output logic             sync_read,
  output logic             edge_pulse,
  output logic [FW-1:0]    sel,
  output logic             in_gap
);

  localparam int unsigned GW = cnt_width(GAP_CYC);

  if (GAP_CYC < 1 || GAP_CYC > 255) begin : g_gap_range
    $error("GAP_CYC must be in 1..255");
  end
  if (DEB_CYC < 1 || DEB_CYC > 65535) begin : g_deb_range
    $error("DEB_CYC must be in 1..65535");
  end

  lane_state_t   state_q;
  logic [FW-1:0] sel_q, pend_q;
  logic [GW-1:0] gap_q;
  logic          pad_w_q, pad_oe_q;

  // Gap counter runs GAP_CYC..1; the edge that would take it to 0 commits and drives func[new].
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      state_q  <= ST_ACTIVE;
      sel_q    <= FW'(FUNC_GPIO);
      pend_q   <= FW'(FUNC_GPIO);
      gap_q    <= '0;
      pad_w_q  <= 1'b0;
      pad_oe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (wr_en && (wr_func != sel_q)) begin
            state_q  <= ST_GAP;
            pend_q   <= wr_func;
            gap_q    <= GW'(GAP_CYC);
            pad_w_q  <= 1'b0;
            pad_oe_q <= 1'b0;
          end else begin
            pad_w_q  <= func_write[sel_q];
            pad_oe_q <= func_writeEnable[sel_q];
          end
        end
        ST_GAP: begin
          if (gap_q == GW'(1)) begin
            state_q  <= ST_ACTIVE;
            sel_q    <= pend_q;
            pad_w_q  <= func_write[pend_q];
            pad_oe_q <= func_writeEnable[pend_q];
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: state_q <= ST_ACTIVE;
      endcase
    end
  end

  logic sync1_q, sync2_q, read_q, edge_q;

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_read;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIN_FUNC_DEBOUNCE_EN
  localparam int unsigned DW = idx_width(DEB_CYC);
  logic [DW-1:0] deb_q;

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      read_q <= 1'b0;
      edge_q <= 1'b0;
      deb_q  <= '0;
    end else if (sync2_q != read_q) begin
      if (deb_q == DW'(DEB_CYC - 1)) begin
        read_q <= sync2_q;
        edge_q <= 1'b1;
        deb_q  <= '0;
      end else begin
        edge_q <= 1'b0;
        deb_q  <= deb_q + DW'(1);
      end
    end else begin
      edge_q <= 1'b0;
      deb_q  <= '0;
    end
  end
`else
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      read_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      read_q <= sync2_q;
      edge_q <= sync2_q ^ read_q;
    end
  end
`endif

  assign pad_write       = pad_w_q;
  assign pad_writeEnable = pad_oe_q;
  assign sync_read       = read_q;
  assign edge_pulse      = edge_q;
  assign sel             = sel_q;
  assign in_gap          = (state_q == ST_GAP);

endmodule

// File: rtl/pin_func_mux.sv
// Pad-function multiplexer top: config decode, ready/err generation and NPINS lanes.
// Optional input debounce is enabled with the PIN_FUNC_DEBOUNCE_EN macro.
module pin_func_mux
  import pin_func_pkg::*;
#(
  parameter int unsigned NPINS   = 16,
  parameter int unsigned NFUNC   = 4,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned DEB_CYC = 8,
  localparam int unsigned PW     = idx_width(NPINS),
  localparam int unsigned FW     = idx_width(NFUNC)
) (
  input  logic                   io_mainClk,
  input  logic                   io_asyncReset_n,
  input  logic                   io_cfg_valid,
  output logic                   io_cfg_ready,
  input  logic [PW-1:0]          io_cfg_pin,
  input  logic [FW-1:0]          io_cfg_func,
  output logic                   io_cfg_err,
  output logic [NPINS*FW-1:0]    io_func_sel,
  input  logic [NPINS*NFUNC-1:0] io_func_write,
  input  logic [NPINS*NFUNC-1:0] io_func_writeEnable,
  output logic [NPINS-1:0]       io_pad_write,
  output logic [NPINS-1:0]       io_pad_writeEnable,
  input  logic [NPINS-1:0]       io_pad_read,
  output logic [NPINS-1:0]       io_sync_read,
  output logic [NPINS-1:0]       io_edge_pulse
);

  localparam int unsigned PSPAN = 1 << PW;

  logic [NPINS-1:0] lane_gap;
  logic [PSPAN-1:0] gap_pad;
  logic             pin_ok, func_ok, accept, err_q;

  // Padded so an out-of-range pin index reads a 0 instead of past the end.
  assign gap_pad      = PSPAN'(lane_gap);
  assign pin_ok       = 32'(io_cfg_pin) < NPINS;
  assign func_ok      = 32'(io_cfg_func) < NFUNC;
  assign io_cfg_ready = ~(pin_ok & gap_pad[io_cfg_pin]);
  assign accept       = io_cfg_valid & io_cfg_ready;

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & ~(pin_ok & func_ok);
    end
  end

  assign io_cfg_err = err_q;

  for (genvar p = 0; p < NPINS; p++) begin : g_lane
    logic lane_wr;
    assign lane_wr = accept & pin_ok & func_ok & (io_cfg_pin == PW'(p));

    pin_func_lane #(
      .NFUNC   (NFUNC),
      .GAP_CYC (GAP_CYC),
      .DEB_CYC (DEB_CYC)
    ) u_lane (
      .io_mainClk       (io_mainClk),
      .io_asyncReset_n  (io_asyncReset_n),
      .wr_en            (lane_wr),
      .wr_func          (io_cfg_func),
      .func_write       (io_func_write[p*NFUNC +: NFUNC]),
      .func_writeEnable (io_func_writeEnable[p*NFUNC +: NFUNC]),
      .pad_read         (io_pad_read[p]),
      .pad_write        (io_pad_write[p]),
      .pad_writeEnable  (io_pad_writeEnable[p]),
      .sync_read        (io_sync_read[p]),
      .edge_pulse       (io_edge_pulse[p]),
      .sel              (io_func_sel[p*FW +: FW]),
      .in_gap           (lane_gap[p])
    );
  end

endmodule

// File: tb/tb_pin_func_mux.sv
// Directed self-checking bench for pin_func_mux (12 pins x 3 functions so bad pin/func are encodable).
module tb_pin_func_mux;

  localparam int unsigned NPINS   = 12;
  localparam int unsigned NFUNC   = 3;
  localparam int unsigned GAP_CYC = 4;
  localparam int unsigned DEB_CYC = 8;
  localparam int unsigned PW      = $clog2(NPINS);
  localparam int unsigned FW      = $clog2(NFUNC);
`ifdef PIN_FUNC_DEBOUNCE_EN
  localparam int unsigned SPACING = 16;
`else
  localparam int unsigned SPACING = 10;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cfg_valid = 1'b0;
  logic                   cfg_ready;
  logic [PW-1:0]          cfg_pin = '0;
  logic [FW-1:0]          cfg_func = '0;
  logic                   cfg_err;
  logic [NPINS*FW-1:0]    func_sel;
  logic [NPINS*NFUNC-1:0] fw = '0;
  logic [NPINS*NFUNC-1:0] fwe = '0;
  logic [NPINS-1:0]       pad_w, pad_we, pad_r = '0, sync_r, edge_p;

  pin_func_mux #(
    .NPINS   (NPINS),
    .NFUNC   (NFUNC),
    .GAP_CYC (GAP_CYC),
    .DEB_CYC (DEB_CYC)
  ) dut (
    .io_mainClk          (clk),
    .io_asyncReset_n     (rst_n),
    .io_cfg_valid        (cfg_valid),
    .io_cfg_ready        (cfg_ready),
    .io_cfg_pin          (cfg_pin),
    .io_cfg_func         (cfg_func),
    .io_cfg_err          (cfg_err),
    .io_func_sel         (func_sel),
    .io_func_write       (fw),
    .io_func_writeEnable (fwe),
    .io_pad_write        (pad_w),
    .io_pad_writeEnable  (pad_we),
    .io_pad_read         (pad_r),
    .io_sync_read        (sync_r),
    .io_edge_pulse       (edge_p)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] sel_of(input int unsigned p);
    return 32'(func_sel[p*FW +: FW]);
  endfunction

  task automatic cfg_write(input int unsigned pin, input int unsigned func, input string tag);
    cfg_pin   = PW'(pin);
    cfg_func  = FW'(func);
    cfg_valid = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NPINS-1:0]       exp_pw;
    logic [NPINS*FW-1:0]    saved;
    int                     waited, pulses, run, maxrun;

    // Reset with random peripheral values
    fw  = (NPINS*NFUNC)'({$urandom(), $urandom()});
    fwe = (NPINS*NFUNC)'({$urandom(), $urandom()});
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(pad_we), 0);
    check("rst_pw", 32'(pad_w), 0);
    check("rst_sel", 32'(func_sel), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_sync", 32'(sync_r), 0);
    check("rst_edge", 32'(edge_p), 0);

    fw  = (NPINS*NFUNC)'({$urandom(), $urandom()});
    fw[3*NFUNC+0] = 1'b0;
    fw[3*NFUNC+1] = 1'b1;
    fw[3*NFUNC+2] = 1'b1;
    fwe = '1;
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < NPINS; p++) exp_pw[p] = fw[p*NFUNC];
    check("rel_pw", 32'(pad_w), 32'(exp_pw));
    check("rel_oe", 32'(pad_we), 32'({NPINS{1'b1}}));

    // Switch pin3 to func2: OE low for GAP_CYC cycles, then func2 drives
    cfg_write(3, 2, "sw");
    for (int i = 0; i < int'(GAP_CYC); i++) begin
      check("gap_oe3", 32'(pad_we[3]), 0);
      check("gap_sel3", sel_of(3), 0);
      tick();
    end
    check("commit_sel3", sel_of(3), 2);
    check("commit_oe3", 32'(pad_we[3]), 1);
    check("commit_pw3", 32'(pad_w[3]), 32'(fw[3*NFUNC+2]));

    // Stall on pin3 while in GAP, pin5 accepted in the same window
    cfg_write(3, 1, "st");
    cfg_pin = 3; cfg_func = 0; cfg_valid = 1'b1;
    #1;
    check("stall_rdy3", 32'(cfg_ready), 0);
    tick();
    cfg_pin = 5; cfg_func = 2;
    #1;
    check("stall_rdy5", 32'(cfg_ready), 1);
    tick();
    cfg_pin = 3; cfg_func = 0;
    #1;
    waited = 0;
    while (!cfg_ready && waited < 10) begin
      tick();
      waited++;
    end
    check("stall_wait", 32'(waited), 2);
    check("stall_sel3", sel_of(3), 1);
    tick();
    cfg_valid = 1'b0;
    check("p5_pre", sel_of(5), 0);
    check("p3_gap_oe", 32'(pad_we[3]), 0);
    tick();
    check("p5_commit", sel_of(5), 2);
    repeat (3) tick();
    check("p3_commit", sel_of(3), 0);
    check("p3_commit_oe", 32'(pad_we[3]), 1);

    // Out-of-range pin and func, then a same-function write
    saved = func_sel;
    cfg_write(NPINS, 0, "epin");
    check("epin_err", 32'(cfg_err), 1);
    check("epin_sel", 32'(func_sel), 32'(saved));
    tick();
    check("epin_err_clr", 32'(cfg_err), 0);
    cfg_write(2, NFUNC, "efunc");
    check("efunc_err", 32'(cfg_err), 1);
    check("efunc_sel", 32'(func_sel), 32'(saved));
    tick();
    check("efunc_err_clr", 32'(cfg_err), 0);
    cfg_write(3, 0, "same");
    check("same_oe3", 32'(pad_we[3]), 1);
    check("same_err", 32'(cfg_err), 0);
    cfg_pin = 3;
    #1;
    check("same_rdy", 32'(cfg_ready), 1);

    // Edge pulses on pad 0
    pulses = 0; run = 0; maxrun = 0;
    pad_r[0] = 1'b1;
    for (int i = 0; i < int'(SPACING); i++) begin
      tick();
      if (edge_p[0]) begin pulses++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check("edge_sync_hi", 32'(sync_r[0]), 1);
    pad_r[0] = 1'b0;
    for (int i = 0; i < int'(SPACING); i++) begin
      tick();
      if (edge_p[0]) begin pulses++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    check("edge_sync_lo", 32'(sync_r[0]), 0);
    check("edge_count", 32'(pulses), 2);
    check("edge_width", 32'(maxrun), 1);

`ifdef PIN_FUNC_DEBOUNCE_EN
    pulses = 0;
    pad_r[0] = 1'b1;
    repeat (3) tick();
    pad_r[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (edge_p[0]) pulses++;
    end
    check("glitch_pulses", 32'(pulses), 0);
    check("glitch_sync", 32'(sync_r[0]), 0);
`endif

    // Reset in the middle of a pin3 gap discards the pending function
    cfg_write(3, 2, "rg");
    tick();
    check("rg_in_gap", 32'(pad_we[3]), 0);
    rst_n = 1'b0;
    #1;
    check("rg_sel", sel_of(3), 0);
    check("rg_oe", 32'(pad_we[3]), 0);
    check("rg_rdy", 32'(cfg_ready), 1);
    tick();
    rst_n = 1'b1;
    repeat (GAP_CYC + 2) tick();
    check("rg_after_sel", sel_of(3), 0);
    check("rg_after_oe", 32'(pad_we[3]), 1);
    check("rg_after_pw", 32'(pad_w[3]), 32'(fw[3*NFUNC+0]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
